// File: rtl/noc_link_receiver.sv
// Credit-based NoC link sink: buffers incoming flits in a circular FIFO and presents them as a
// valid/ready stream, returning one credit per consumed flit. Optional: NOC_RX_OVERFLOW_CHECK_EN.
module noc_link_receiver #(
    parameter int FLIT_WIDTH   = 64,
    parameter int DEST_WIDTH   = 6,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                          clk_noc,
    input  logic                          rst_noc,
    input  logic [FLIT_WIDTH-1:0]         data_in,
    input  logic [DEST_WIDTH-1:0]         dest_in,
    input  logic                          is_tail_in,
    input  logic                          send_in,
    output logic                          credit_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FLIT_WIDTH-1:0]         out_data,
    output logic [DEST_WIDTH-1:0]         out_dest,
    output logic                          out_is_tail,
    output logic                          out_sop,
    output logic [$clog2(BUFFER_DEPTH):0] occupancy,
    output logic [15:0]                   pkt_count,
    output logic                          overflow_err
);

    localparam int PTR_W   = $clog2(BUFFER_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam logic [OCC_W-1:0] FULL_LEVEL = OCC_W'(BUFFER_DEPTH);

    typedef enum logic {
        SOP  = 1'b0,
        BODY = 1'b1
    } pkt_state_t;

    logic [ENTRY_W-1:0] r_mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;
    logic               r_credit;
    logic [15:0]        r_pkt_count;
    pkt_state_t         r_state;
    pkt_state_t         w_state_next;

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic [ENTRY_W-1:0] w_head;

    assign w_valid = (r_occ != '0);
    assign w_pop   = w_valid && out_ready;

`ifdef NOC_RX_OVERFLOW_CHECK_EN
    logic w_full;
    logic w_drop;
    logic r_overflow;

    // A same-cycle pop frees the slot, so only a push into a full FIFO with no pop is dropped.
    assign w_full = (r_occ == FULL_LEVEL);
    assign w_drop = send_in && w_full && !w_pop;
    assign w_push = send_in && !w_drop;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_err = r_overflow;
`else
    assign w_push       = send_in;
    assign overflow_err = 1'b0;
`endif

    always_ff @(posedge clk_noc) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {data_in, dest_in, is_tail_in};
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign out_data    = w_head[ENTRY_W-1 -: FLIT_WIDTH];
    assign out_dest    = w_head[DEST_WIDTH:1];
    assign out_is_tail = w_head[0];
    assign out_valid   = w_valid;
    assign occupancy   = r_occ;

    // Credit is a registered copy of the pop strobe, so it lands one cycle after the pop.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_credit    <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_credit <= w_pop;
            if (w_pop && out_is_tail) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign credit_out = r_credit;
    assign pkt_count  = r_pkt_count;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_state <= SOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_pop) begin
            case (r_state)
                SOP:     w_state_next = out_is_tail ? SOP : BODY;
                BODY:    w_state_next = out_is_tail ? SOP : BODY;
                default: w_state_next = SOP;
            endcase
        end
    end

    assign out_sop = (r_state == SOP) && w_valid;

endmodule

// File: tb/tb_noc_link_receiver.sv
// Scoreboard bench for noc_link_receiver: directed stimulus queues expected flits, a negedge
// monitor pops and compares them; overflow test built when NOC_RX_OVERFLOW_CHECK_EN is defined.
module tb_noc_link_receiver;

    localparam int FW    = 64;
    localparam int DW    = 6;
    localparam int DEPTH = 8;

    typedef struct {
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          tail;
        logic          sop;
    } expFlit_t;

    logic          clk_noc = 1'b0;
    logic          rst_noc = 1'b0;
    logic [FW-1:0] data_in = '0;
    logic [DW-1:0] dest_in = '0;
    logic          is_tail_in = 1'b0;
    logic          send_in = 1'b0;
    logic          credit_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] out_data;
    logic [DW-1:0] out_dest;
    logic          out_is_tail;
    logic          out_sop;
    logic [3:0]    occupancy;
    logic [15:0]   pkt_count;
    logic          overflow_err;

    expFlit_t expQ[$];
    expFlit_t monFlit;
    int  checkCount = 0;
    int  passCount = 0;
    int  creditCount = 0;
    logic prevTail = 1'b1;
    logic prevPop = 1'b0;

    noc_link_receiver #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) dut (
        .clk_noc(clk_noc), .rst_noc(rst_noc),
        .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
        .credit_out(credit_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dest(out_dest), .out_is_tail(out_is_tail), .out_sop(out_sop),
        .occupancy(occupancy), .pkt_count(pkt_count), .overflow_err(overflow_err)
    );

    always #5 clk_noc = ~clk_noc;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of link/consumer inputs; accepted pushes are queued with their expected SOP.
    task automatic applyStimulus(input logic push, input logic [FW-1:0] d, input logic [DW-1:0] dst,
                                 input logic tail, input logic rdy, input logic dropExpected);
        expFlit_t f;
        @(posedge clk_noc);
        #1;
        send_in    = push;
        data_in    = d;
        dest_in    = dst;
        is_tail_in = tail;
        out_ready  = rdy;
        if (push && !dropExpected) begin
            f.data = d;
            f.dest = dst;
            f.tail = tail;
            f.sop  = prevTail;
            expQ.push_back(f);
            prevTail = tail;
        end
    endtask

    task automatic idleCycle(input logic rdy);
        applyStimulus(1'b0, '0, '0, 1'b0, rdy, 1'b0);
    endtask

    // Monitor: samples away from the active edge, checks every consumed flit and credit timing.
    always @(negedge clk_noc) begin
        if (rst_noc) begin
            prevPop = 1'b0;
        end else begin
            if (prevPop || credit_out) begin
                checkOutput("credit_timing", {63'd0, credit_out}, {63'd0, prevPop});
            end
            if (credit_out) begin
                creditCount++;
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_flit", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    monFlit = expQ.pop_front();
                    checkOutput("flit_data", out_data, monFlit.data);
                    checkOutput("flit_dest", {58'd0, out_dest}, {58'd0, monFlit.dest});
                    checkOutput("flit_tail", {63'd0, out_is_tail}, {63'd0, monFlit.tail});
                    checkOutput("flit_sop", {63'd0, out_sop}, {63'd0, monFlit.sop});
                end
                prevPop = 1'b1;
            end else begin
                prevPop = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int creditSnap;
        int credits;
        int sent;
        int cyc;
        int tailsSent;
        logic tailBit;

        // Power-on reset
        #1;
        rst_noc = 1'b1;
        #1;
        checkOutput("reset_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_credit", {63'd0, credit_out}, 64'd0);
        checkOutput("reset_occupancy", {60'd0, occupancy}, 64'd0);
        checkOutput("reset_pkt_count", {48'd0, pkt_count}, 64'd0);
        checkOutput("reset_overflow", {63'd0, overflow_err}, 64'd0);
        checkOutput("reset_sop", {63'd0, out_sop}, 64'd0);
        repeat (2) @(posedge clk_noc);
        #1;
        rst_noc = 1'b0;

        // Single flit
        $display("[TB] single flit");
        creditSnap = creditCount;
        applyStimulus(1'b1, 64'hA5, 6'd3, 1'b1, 1'b1, 1'b0);
        checkOutput("single_no_bypass", {63'd0, out_valid}, 64'd0);
        idleCycle(1'b1);
        checkOutput("single_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("single_sop", {63'd0, out_sop}, 64'd1);
        checkOutput("single_tail", {63'd0, out_is_tail}, 64'd1);
        checkOutput("single_data", out_data, 64'hA5);
        checkOutput("single_credit_early", {63'd0, credit_out}, 64'd0);
        idleCycle(1'b1);
        checkOutput("single_credit", {63'd0, credit_out}, 64'd1);
        checkOutput("single_pkt_count", {48'd0, pkt_count}, 64'd1);
        checkOutput("single_occupancy", {60'd0, occupancy}, 64'd0);
        idleCycle(1'b1);
        checkOutput("single_credit_once", {63'd0, credit_out}, 64'd0);

        // Fill (3-flit + 5-flit packets) and drain
        $display("[TB] fill and drain");
        creditSnap = creditCount;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 64'h100 + 64'(i), 6'(i), (i == 2) || (i == 7), 1'b0, 1'b0);
        end
        idleCycle(1'b0);
        checkOutput("fill_occupancy", {60'd0, occupancy}, 64'd8);
        checkOutput("fill_head_data", out_data, 64'h100);
        checkOutput("fill_head_sop", {63'd0, out_sop}, 64'd1);
        idleCycle(1'b0);
        checkOutput("fill_hold_data", out_data, 64'h100);
        checkOutput("fill_hold_occupancy", {60'd0, occupancy}, 64'd8);
        for (int i = 0; i < 11; i++) idleCycle(1'b1);
        checkOutput("drain_credits", 64'(creditCount - creditSnap), 64'd8);
        checkOutput("drain_pkt_count", {48'd0, pkt_count}, 64'd3);
        checkOutput("drain_occupancy", {60'd0, occupancy}, 64'd0);

        // Full with simultaneous push and pop, pointers wrap several times
        $display("[TB] full with simultaneous push/pop");
        creditSnap = creditCount;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 64'h4000 + 64'(i), 6'(i + 10), (i % 4) == 3, 1'b0, 1'b0);
        end
        for (int i = 8; i < 28; i++) begin
            applyStimulus(1'b1, 64'h4000 + 64'(i), 6'(i + 10), (i % 4) == 3, 1'b1, 1'b0);
            checkOutput("full_occupancy", {60'd0, occupancy}, 64'd8);
        end
        for (int i = 0; i < 10; i++) idleCycle(1'b1);
        checkOutput("full_credits", 64'(creditCount - creditSnap), 64'd28);
        checkOutput("full_pkt_count", {48'd0, pkt_count}, 64'd10);
        checkOutput("full_drained", {60'd0, occupancy}, 64'd0);

        // Reset asserted mid-packet with a credit pending
        $display("[TB] reset mid-traffic");
        applyStimulus(1'b1, 64'h700, 6'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h701, 6'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h702, 6'd1, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b1);
        @(posedge clk_noc);
        #1;
        rst_noc = 1'b1;
        send_in = 1'b0;
        out_ready = 1'b0;
        expQ.delete();
        prevTail = 1'b1;
        #1;
        checkOutput("midreset_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midreset_credit", {63'd0, credit_out}, 64'd0);
        checkOutput("midreset_occupancy", {60'd0, occupancy}, 64'd0);
        checkOutput("midreset_pkt_count", {48'd0, pkt_count}, 64'd0);
        checkOutput("midreset_sop", {63'd0, out_sop}, 64'd0);
        @(posedge clk_noc);
        #1;
        rst_noc = 1'b0;
        idleCycle(1'b1);
        checkOutput("postreset_occupancy", {60'd0, occupancy}, 64'd0);
        checkOutput("postreset_valid", {63'd0, out_valid}, 64'd0);

        // Back-pressure jitter under an upstream credit model
        $display("[TB] back-pressure jitter");
        creditSnap = creditCount;
        credits = DEPTH;
        sent = 0;
        cyc = 0;
        tailsSent = 0;
        while ((sent < 1000 || expQ.size() != 0) && cyc < 20000) begin
            credits += int'(credit_out);
            if (sent < 1000 && credits > 0) begin
                tailBit = ($urandom_range(0, 3) == 0) || (sent == 999);
                applyStimulus(1'b1, {$urandom, $urandom}, 6'($urandom_range(0, 63)), tailBit,
                              1'($urandom_range(0, 1)), 1'b0);
                credits--;
                sent++;
                if (tailBit) tailsSent++;
            end else begin
                idleCycle(1'($urandom_range(0, 1)));
            end
            cyc++;
        end
        if (cyc >= 20000) begin
            checkOutput("jitter_timeout", 64'(cyc), 64'd0);
        end
        for (int i = 0; i < 3; i++) idleCycle(1'b1);
        checkOutput("jitter_credits", 64'(creditCount - creditSnap), 64'd1000);
        checkOutput("jitter_pkt_count", {48'd0, pkt_count}, 64'(tailsSent));
        checkOutput("jitter_overflow", {63'd0, overflow_err}, 64'd0);
        checkOutput("jitter_occupancy", {60'd0, occupancy}, 64'd0);

`ifdef NOC_RX_OVERFLOW_CHECK_EN
        // Ninth flit into a full buffer must be dropped and flagged
        $display("[TB] overflow");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 64'h900 + 64'(i), 6'd5, i == 7, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 64'hDEAD, 6'd7, 1'b1, 1'b0, 1'b1);
        idleCycle(1'b0);
        checkOutput("overflow_flag", {63'd0, overflow_err}, 64'd1);
        checkOutput("overflow_occupancy", {60'd0, occupancy}, 64'd8);
        checkOutput("overflow_head", out_data, 64'h900);
        for (int i = 0; i < 10; i++) idleCycle(1'b1);
        checkOutput("overflow_sticky", {63'd0, overflow_err}, 64'd1);
        checkOutput("overflow_drained", {60'd0, occupancy}, 64'd0);
`else
        checkOutput("overflow_tied_low", {63'd0, overflow_err}, 64'd0);
`endif

        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
